// File: rtl/mem_access_stage_if.sv
// Memory port between the memory-access stage and the data memory.
// Signals:
//   mem_req    stage -> memory  request valid, held for the whole REQ phase
//   mem_we     stage -> memory  1 = write
//   mem_addr   stage -> memory  word address (low two bits always 0)
//   mem_wdata  stage -> memory  lane-replicated store data
//   mem_be     stage -> memory  byte enables, bit i covers byte [8i+7:8i]
//   mem_ready  memory -> stage  request accepted/completed this cycle
//   mem_rdata  memory -> stage  read data, valid with mem_ready
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage, downstream of the ALU.
// Loads/stores use alu_result as the effective address and rt_value as store
// data; every other opcode passes alu_result through to writeback.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   start                  instruction valid (sampled only when idle)
//   opcode                 instruction opcode
//   alu_result, rt_value   effective address / passthrough value, store data
//   mem                    memory port (master side)
//   busy                   transaction in progress
//   done                   one-cycle completion pulse
//   wb_data                writeback value, held until the next done
//   addr_error, bus_error  misaligned access / memory timeout, valid with done
//   link_valid, link_addr  LL reservation state
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [5:0]           opcode,
  input  logic [31:0]          alu_result,
  input  logic [31:0]          rt_value,
  mem_access_stage_if.master   mem,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          wb_data,
  output logic                 addr_error,
  output logic                 bus_error,
  output logic                 link_valid,
  output logic [31:0]          link_addr
);

  typedef enum logic [5:0] {
    OP_LW  = 6'h23,
    OP_LBU = 6'h24,
    OP_LHU = 6'h25,
    OP_LL  = 6'h30,
    OP_SB  = 6'h28,
    OP_SH  = 6'h29,
    OP_SW  = 6'h2b
  } opcode_e;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state, state_d;
  logic [5:0]    op_q;
  logic [1:0]    addr_lo_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q, res_q;
  logic [3:0]    be_q;
  logic [CW-1:0] cnt;

  // Decode of the incoming instruction (only meaningful in IDLE)
  logic          is_mem, is_store, aligned;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   load_d;

  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    be_d     = 4'b1111;
    wdata_d  = '0;
    case (opcode)
      OP_LW, OP_LL: begin
        is_mem  = 1'b1;
        aligned = (alu_result[1:0] == 2'b00);
      end
      OP_LHU: begin
        is_mem  = 1'b1;
        aligned = !alu_result[0];
      end
      OP_LBU: is_mem = 1'b1;
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        aligned  = (alu_result[1:0] == 2'b00);
        wdata_d  = rt_value;
      end
      OP_SH: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        aligned  = !alu_result[0];
        wdata_d  = {2{rt_value[15:0]}};
        be_d     = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        wdata_d  = {4{rt_value[7:0]}};
        be_d     = 4'b0001 << alu_result[1:0];
      end
      default: ;
    endcase
  end

  // Load result extraction from the returned word, using the latched lane
  always_comb begin
    load_d = mem.mem_rdata;
    case (op_q)
      OP_LHU: load_d = {16'h0, addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0]};
      OP_LBU: begin
        case (addr_lo_q)
          2'd0:    load_d = {24'h0, mem.mem_rdata[7:0]};
          2'd1:    load_d = {24'h0, mem.mem_rdata[15:8]};
          2'd2:    load_d = {24'h0, mem.mem_rdata[23:16]};
          default: load_d = {24'h0, mem.mem_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = (is_mem && aligned) ? REQ : RESP;
      REQ:  if (mem.mem_ready || cnt == CNT_LAST) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_lo_q  <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      cnt        <= '0;
      res_q      <= '0;
      done       <= 1'b0;
      wb_data    <= '0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      state <= state_d;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          addr_error <= 1'b0;
          bus_error  <= 1'b0;
          op_q       <= opcode;
          addr_lo_q  <= alu_result[1:0];
          if (is_mem && aligned) begin
            we_q    <= is_store;
            addr_q  <= {alu_result[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt     <= '0;
          end else if (is_mem) begin
            addr_error <= 1'b1;
            res_q      <= '0;
          end else begin
            res_q <= alu_result;
          end
        end
        REQ: begin
          if (mem.mem_ready) begin
            res_q <= we_q ? '0 : load_d;
            if (op_q == OP_LL) begin
              link_valid <= 1'b1;
              link_addr  <= addr_q;
            end else if (we_q && addr_q == link_addr) begin
              link_valid <= 1'b0;
            end
          end else if (cnt == CNT_LAST) begin
            bus_error <= 1'b1;
            res_q     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          done    <= 1'b1;
          wb_data <= res_q;
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign mem.mem_req   = (state == REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] alu_result, rt_value;
  logic        busy, done, addr_error, bus_error, link_valid;
  logic [31:0] wb_data, link_addr;

  int vectors = 0;
  int miscompares = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .alu_result (alu_result),
    .rt_value   (rt_value),
    .mem        (bus),
    .busy       (busy),
    .done       (done),
    .wb_data    (wb_data),
    .addr_error (addr_error),
    .bus_error  (bus_error),
    .link_valid (link_valid),
    .link_addr  (link_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and run until done (bounded). ready_at = REQ cycle
  // number on which mem_ready is raised (0 = never). Snapshot of the first REQ
  // cycle's bus outputs is returned, plus whether they changed during REQ.
  task automatic run(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] rt,
                     input logic [31:0] rdata, input int ready_at, input bit pulse,
                     output int lat, output int reqs, output logic s_we,
                     output logic [31:0] s_addr, output logic [31:0] s_wdata,
                     output logic [3:0] s_be, output logic changed);
    start = 1'b1; opcode = op; alu_result = alu; rt_value = rt;
    bus.mem_ready = 1'b0; bus.mem_rdata = rdata;
    lat = 0; reqs = 0; changed = 1'b0;
    s_we = 1'b0; s_addr = '0; s_wdata = '0; s_be = '0;
    do begin
      tick();
      lat++;
      if (pulse && (lat == 4 || lat == 8)) begin
        start = 1'b1; opcode = 6'h00; alu_result = 32'hFFFF_0000;
      end else begin
        start = 1'b0;
      end
      if (bus.mem_req) begin
        reqs++;
        if (reqs == 1) begin
          s_we = bus.mem_we; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata; s_be = bus.mem_be;
        end else if (bus.mem_we !== s_we || bus.mem_addr !== s_addr ||
                     bus.mem_wdata !== s_wdata || bus.mem_be !== s_be) begin
          changed = 1'b1;
        end
        bus.mem_ready = (reqs == ready_at);
      end else begin
        bus.mem_ready = 1'b0;
      end
    end while (!done && lat < 64);
    bus.mem_ready = 1'b0;
    start = 1'b0;
  endtask

  int lat, reqs;
  logic s_we, changed;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_be;

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; alu_result = '0; rt_value = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_link_valid", {31'b0, link_valid}, 32'd0);
    chk("rst_link_addr", link_addr, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_errors", {30'b0, addr_error, bus_error}, 32'd0);
    rst_n = 1'b1;
    tick();

    // SW, ready on the first REQ cycle
    run(6'h2b, 32'h100, 32'hDEADBEEF, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sw_latency", lat, 3);
    chk("sw_reqs", reqs, 1);
    chk("sw_addr", s_addr, 32'h100);
    chk("sw_be", {28'b0, s_be}, 32'hF);
    chk("sw_wdata", s_wdata, 32'hDEADBEEF);
    chk("sw_we", {31'b0, s_we}, 32'd1);
    tick();
    chk("done_pulse_width", {31'b0, done}, 32'd0);

    // LBU lane 3, ready on second REQ cycle
    run(6'h24, 32'h203, 32'h0, 32'h80AABBCC, 2, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("lbu_latency", lat, 4);
    chk("lbu_reqs", reqs, 2);
    chk("lbu_const", {31'b0, changed}, 32'd0);
    chk("lbu_addr", s_addr, 32'h200);
    chk("lbu_we_be", {27'b0, s_we, s_be}, 32'h0F);
    chk("lbu_wb", wb_data, 32'h00000080);
    tick(); tick();
    chk("wb_held", wb_data, 32'h00000080);

    // LHU upper half
    run(6'h25, 32'h602, 32'h0, 32'hCAFEBABE, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("lhu_wb", wb_data, 32'h0000CAFE);

    // SH upper half, then misaligned SH
    run(6'h29, 32'h302, 32'h1234ABCD, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sh_be", {28'b0, s_be}, 32'hC);
    chk("sh_wdata", s_wdata, 32'hABCDABCD);
    chk("sh_addr", s_addr, 32'h300);
    run(6'h29, 32'h301, 32'h1234ABCD, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sh_mis_reqs", reqs, 0);
    chk("sh_mis_latency", lat, 2);
    chk("sh_mis_addr_error", {31'b0, addr_error}, 32'd1);
    chk("sh_mis_wb", wb_data, 32'd0);

    // LL then SB to the same word clears the link
    run(6'h30, 32'h400, 32'h0, 32'h55667788, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("ll_wb", wb_data, 32'h55667788);
    chk("ll_addr_error_cleared", {31'b0, addr_error}, 32'd0);
    chk("ll_link_valid", {31'b0, link_valid}, 32'd1);
    chk("ll_link_addr", link_addr, 32'h400);
    run(6'h28, 32'h402, 32'h000000A5, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sb_be", {28'b0, s_be}, 32'h4);
    chk("sb_wdata", s_wdata, 32'hA5A5A5A5);
    chk("sb_same_word_link", {31'b0, link_valid}, 32'd0);

    // LL then SB to another word keeps the link
    run(6'h30, 32'h400, 32'h0, 32'h1, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    run(6'h28, 32'h404, 32'h0000003C, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sb_other_be", {28'b0, s_be}, 32'h1);
    chk("sb_other_link_valid", {31'b0, link_valid}, 32'd1);
    chk("sb_other_link_addr", link_addr, 32'h400);

    // Misaligned SW to the linked word leaves the link alone
    run(6'h2b, 32'h402, 32'h0, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sw_mis_addr_error", {31'b0, addr_error}, 32'd1);
    chk("sw_mis_link_valid", {31'b0, link_valid}, 32'd1);

    // LW timeout with start pulses while busy
    run(6'h23, 32'h500, 32'h0, 32'h0, 0, 1'b1, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("to_reqs", reqs, 16);
    chk("to_latency", lat, 18);
    chk("to_const", {31'b0, changed}, 32'd0);
    chk("to_bus_error", {31'b0, bus_error}, 32'd1);
    chk("to_wb", wb_data, 32'd0);
    tick(); tick();
    chk("to_no_queued_start", {30'b0, busy, done}, 32'd0);

    // SW to the linked word that times out leaves the link alone
    run(6'h2b, 32'h400, 32'h0, 32'h0, 0, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("sw_to_link_valid", {31'b0, link_valid}, 32'd1);

    // Passthrough
    run(6'h00, 32'h7, 32'h0, 32'h0, 1, 1'b0, lat, reqs, s_we, s_addr, s_wdata, s_be, changed);
    chk("pt_reqs", reqs, 0);
    chk("pt_latency", lat, 2);
    chk("pt_wb", wb_data, 32'h7);
    chk("pt_bus_error_cleared", {31'b0, bus_error}, 32'd0);

    // Reset during REQ
    start = 1'b1; opcode = 6'h23; alu_result = 32'h700; bus.mem_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("rreq_mem_req", {31'b0, bus.mem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rreq_mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
    chk("rreq_outputs", {29'b0, busy, done, link_valid}, 32'd0);
    chk("rreq_wb", wb_data, 32'd0);
    chk("rreq_link_addr", link_addr, 32'd0);
    chk("rreq_mem_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) lat++;
    end
    chk("rreq_no_done", lat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the ALU.
- Consumes the ALU result as the effective address for loads and stores (LW, LBU, LHU, LL, SW, SH, SB) and rt_value as store data.
- Drives a word-wide memory port through a req/ready handshake, with byte-lane formatting, alignment checks, a timeout and an LL link register.
- Non-memory instructions pass the ALU result straight through to writeback.

Parameters:
- TIMEOUT, 16, maximum REQ-state cycles without mem_ready before a bus error. Must be ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  instruction valid; sampled only in IDLE
- opcode  in  6  instruction opcode
- alu_result  in  32  effective address, or passthrough value
- rt_value  in  32  store data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {alu_result[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables; bit i = byte [8i+7:8i]
- mem_ready  in  1  memory accepted/completed the request this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- wb_data  out  32  load result or passthrough value; held until the next done
- addr_error  out  1  misaligned access; valid with done
- bus_error  out  1  timeout; valid with done
- link_valid  out  1  LL reservation active
- link_addr  out  32  word address of the reservation

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. All outputs are 0, including link_valid, link_addr and wb_data. Reset mid-transaction drops mem_req on the following edge with no done.
- Memory opcodes: LW 0x23, LBU 0x24, LHU 0x25, LL 0x30, SB 0x28, SH 0x29, SW 0x2b. Any other opcode is passthrough.
- States:
  - IDLE → REQ on start with an aligned memory opcode. Latch opcode, address, data and byte enables.
  - IDLE → RESP on start with a passthrough opcode (wb_data=alu_result) or a misaligned access (addr_error=1, no memory request).
  - REQ → RESP when mem_ready=1.
  - REQ → RESP with bus_error=1 when TIMEOUT consecutive REQ cycles pass without mem_ready.
  - RESP → IDLE unconditionally.
- REQ outputs: mem_req=1. mem_we/mem_addr/mem_wdata/mem_be stay constant for the whole of REQ. mem_req=0 in all other states.
- Latency:
  - Passthrough/error: done 2 cycles after start.
  - Memory: done 1 cycle after the mem_ready cycle; minimum 3 cycles after start.
- start is ignored while busy=1. It is not queued.
- Alignment:
  - LW/LL/SW require addr[1:0]=0.
  - LHU/SH require addr[0]=0.
  - LBU/SB are always aligned.
- Store formatting:
  - SW: be=1111, wdata=rt.
  - SH: wdata={2{rt[15:0]}}, be=addr[1]?1100:0011.
  - SB: wdata={4{rt[7:0]}}, be=0001<<addr[1:0].
- Loads: mem_we=0, be=1111.
  - LW/LL: wb_data=rdata.
  - LHU: zero-extended rdata halfword selected by addr[1].
  - LBU: zero-extended rdata byte selected by addr[1:0].
- Link register:
  - A completed LL sets link_valid=1 and link_addr=word address.
  - A completed store (mem_ready seen) whose word address equals link_addr clears link_valid.
  - Stores that are misaligned or time out do not affect the link.
- Errors: on error, wb_data is 0. addr_error and bus_error are cleared at the next start.
- The timeout counter is cleared on entry to REQ and saturates; it does not wrap.

Test Plan:
- SW alu_result=0x100, rt=0xDEADBEEF, mem_ready high on first REQ cycle → mem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; done exactly 3 cycles after start.
- LBU addr=0x203, mem_rdata=0x80AABBCC, ready after 2 REQ cycles → wb_data=0x00000080; mem_req held 2 cycles with constant outputs; done 1 cycle later.
- SH addr=0x302, rt=0x1234ABCD → be=1100, wdata=0xABCDABCD. SH addr=0x301 → no mem_req, done with addr_error=1, wb_data=0.
- LL addr=0x400, then SB addr=0x402 completes → link_valid 1 then 0. A second test with SB to addr=0x404 → link_valid stays 1, link_addr=0x400.
- TIMEOUT=16, LW with mem_ready held 0 → mem_req high exactly 16 cycles, then done with bus_error=1; start pulses during busy ignored.
- Passthrough opcode 0x00, alu_result=0x7 → no mem_req, wb_data=0x7, done 2 cycles after start. Separately, rst_n=0 during REQ → mem_req=0 and all outputs 0 on the next edge, no done.
